// File: rtl/intpol2_dn_ctrl.sv
// Control path for the quadratic interpolator: L = 2^LOG2_L phases, NCH interleaved channels.
// Define INTPOL_STALL_CNT_EN to add the 32-bit stall_cnt output (saturating stall-cycle counter).
module intpol2_dn_ctrl #(
  parameter int LOG2_L         = 2,
  parameter int NCH            = 2,
  parameter int CH_W           = 1,
  parameter int DP_LAT         = 3,
  parameter int CONFIG_WIDTH   = 32,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic                      bypass,
  input  logic [CONFIG_WIDTH-1:0]   ilen,
  input  logic                      Empty_i,
  input  logic                      Afull_i,
  output logic                      Read_Enable,
  output logic [MEM_ADDR_WIDTH-1:0] M_addr,
  output logic                      Ld_win,
  output logic [CH_W-1:0]           ch_sel,
  output logic [LOG2_L-1:0]         sel_xi,
  output logic                      en_sum,
  output logic                      Write_Enable,
  output logic [MEM_ADDR_WIDTH-1:0] Y_addr,
  output logic                      FIFO_bypass,
  output logic                      busy,
  output logic                      done,
  output logic                      stop_empty,
  output logic                      stop_Afull,
  output logic                      clear
`ifdef INTPOL_STALL_CNT_EN
  , output logic [31:0]             stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_READ  = 3'd2,
    S_COMP  = 3'd3,
    S_BYP   = 3'd4,
    S_FLUSH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [CONFIG_WIDTH-1:0]   r_k;
  logic [CONFIG_WIDTH-1:0]   r_ilen;
  logic [CH_W-1:0]           r_c;
  logic [LOG2_L-1:0]         r_p;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [MEM_ADDR_WIDTH-1:0] r_yaddr;
  logic                      r_bypass;
  logic                      r_mode;
  logic                      r_ld_win;
  logic                      r_en_sum;
  logic [CH_W-1:0]           r_ch_sel;
  logic [LOG2_L-1:0]         r_sel_xi;
  logic [DP_LAT-1:0]         r_dly;
  logic [DP_LAT-1:0]         w_dly_low;

  logic w_read_en;
  logic w_sum_fire;
  logic w_stop_empty;
  logic w_stop_afull;
  logic w_last_ch;
  logic w_last_p;
  logic w_last_k;
  logic w_stall_rd;
  logic w_stall_wr;

  assign w_last_ch  = (r_c == CH_W'(NCH - 1));
  assign w_last_p   = (r_p == {LOG2_L{1'b1}});
  assign w_last_k   = ((r_k + CONFIG_WIDTH'(1)) == r_ilen);
  assign w_stall_rd = r_mode & Empty_i;
  assign w_stall_wr = r_mode & Afull_i;
  // The MSB of the delay line is the write happening this cycle, so it does not block FLUSH exit.
  assign w_dly_low  = r_dly << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_read_en    = 1'b0;
    w_sum_fire   = 1'b0;
    w_stop_empty = 1'b0;
    w_stop_afull = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_CLEAR;
        else       w_next_state = S_IDLE;
      end
      S_CLEAR: begin
        if ((!r_bypass && (r_ilen < CONFIG_WIDTH'(3))) || (r_bypass && (r_ilen == '0)))
          w_next_state = S_FLUSH;
        else
          w_next_state = S_READ;
      end
      S_READ: begin
        if (w_stall_rd) begin
          w_stop_empty = 1'b1;
        end else begin
          w_read_en = 1'b1;
          if (w_last_ch && r_bypass)                          w_next_state = S_BYP;
          else if (w_last_ch && (r_k >= CONFIG_WIDTH'(2)))    w_next_state = S_COMP;
          else                                                w_next_state = S_READ;
        end
      end
      S_COMP: begin
        if (w_stall_wr) begin
          w_stop_afull = 1'b1;
        end else begin
          w_sum_fire = 1'b1;
          if (w_last_ch && w_last_p) w_next_state = w_last_k ? S_FLUSH : S_READ;
          else                       w_next_state = S_COMP;
        end
      end
      S_BYP: begin
        if (w_stall_wr) begin
          w_stop_afull = 1'b1;
        end else begin
          w_sum_fire = 1'b1;
          if (w_last_ch) w_next_state = w_last_k ? S_FLUSH : S_READ;
          else           w_next_state = S_BYP;
        end
      end
      S_FLUSH: begin
        if (!r_en_sum && (w_dly_low == '0)) w_next_state = S_DONE;
        else                                w_next_state = S_FLUSH;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Counters, window/compute strobes and the write-latency delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= '0;
      r_ilen   <= '0;
      r_c      <= '0;
      r_p      <= '0;
      r_addr   <= '0;
      r_yaddr  <= '0;
      r_bypass <= 1'b0;
      r_mode   <= 1'b0;
      r_ld_win <= 1'b0;
      r_en_sum <= 1'b0;
      r_ch_sel <= '0;
      r_sel_xi <= '0;
      r_dly    <= '0;
    end else begin
      r_ld_win <= w_read_en;
      r_en_sum <= w_sum_fire;
      r_dly    <= (r_dly << 1) | DP_LAT'(r_en_sum);
      if (r_dly[DP_LAT-1]) r_yaddr <= r_yaddr + MEM_ADDR_WIDTH'(1);
      if ((r_state == S_IDLE) && start) begin
        r_ilen   <= ilen;
        r_bypass <= bypass;
        r_mode   <= mode;
      end
      if (w_read_en) begin
        r_addr   <= r_addr + MEM_ADDR_WIDTH'(1);
        r_ch_sel <= r_c;
        r_c      <= w_last_ch ? '0 : r_c + CH_W'(1);
        if (w_last_ch && !r_bypass && (r_k < CONFIG_WIDTH'(2))) r_k <= r_k + CONFIG_WIDTH'(1);
      end
      if (w_sum_fire && (r_state == S_COMP)) begin
        r_ch_sel <= r_c;
        r_sel_xi <= r_p;
        r_p      <= r_p + LOG2_L'(1);
        if (w_last_p) r_c <= w_last_ch ? '0 : r_c + CH_W'(1);
        if (w_last_p && w_last_ch) r_k <= r_k + CONFIG_WIDTH'(1);
      end
      if (w_sum_fire && (r_state == S_BYP)) begin
        r_ch_sel <= r_c;
        r_sel_xi <= '0;
        r_c      <= w_last_ch ? '0 : r_c + CH_W'(1);
        if (w_last_ch) r_k <= r_k + CONFIG_WIDTH'(1);
      end
      if (r_state == S_CLEAR) begin
        r_k      <= '0;
        r_c      <= '0;
        r_p      <= '0;
        r_addr   <= '0;
        r_yaddr  <= '0;
        r_ch_sel <= '0;
        r_sel_xi <= '0;
      end
    end
  end

`ifdef INTPOL_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of stalled cycles; left untouched after the run completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (r_state == S_CLEAR) begin
      r_stall_cnt <= 32'd0;
    end else if ((w_stop_empty || w_stop_afull) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign Read_Enable  = w_read_en;
  assign stop_empty   = w_stop_empty;
  assign stop_Afull   = w_stop_afull;
  assign M_addr       = r_addr;
  assign Ld_win       = r_ld_win;
  assign ch_sel       = r_ch_sel;
  assign sel_xi       = r_sel_xi;
  assign en_sum       = r_en_sum;
  assign Write_Enable = r_dly[DP_LAT-1];
  assign Y_addr       = r_yaddr;
  assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign FIFO_bypass  = busy && r_bypass;
  assign done         = (r_state == S_DONE);
  assign clear        = (r_state == S_CLEAR);

endmodule

// File: tb/tb_intpol2_dn_ctrl.sv
// Directed self-checking bench for intpol2_dn_ctrl (LOG2_L=2, NCH=2, DP_LAT=3).
module tb_intpol2_dn_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        bypass = 1'b0;
  logic [31:0] ilen = 32'd0;
  logic        Empty_i = 1'b0;
  logic        Afull_i = 1'b0;
  logic        Read_Enable;
  logic [15:0] M_addr;
  logic        Ld_win;
  logic [0:0]  ch_sel;
  logic [1:0]  sel_xi;
  logic        en_sum;
  logic        Write_Enable;
  logic [15:0] Y_addr;
  logic        FIFO_bypass;
  logic        busy;
  logic        done;
  logic        stop_empty;
  logic        stop_Afull;
  logic        clear;
`ifdef INTPOL_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  intpol2_dn_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .bypass(bypass), .ilen(ilen),
    .Empty_i(Empty_i), .Afull_i(Afull_i), .Read_Enable(Read_Enable), .M_addr(M_addr),
    .Ld_win(Ld_win), .ch_sel(ch_sel), .sel_xi(sel_xi), .en_sum(en_sum),
    .Write_Enable(Write_Enable), .Y_addr(Y_addr), .FIFO_bypass(FIFO_bypass), .busy(busy),
    .done(done), .stop_empty(stop_empty), .stop_Afull(stop_Afull), .clear(clear)
`ifdef INTPOL_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic exp_byp = 1'b0;

  // Event monitor: tallies per run (restarted on clear) against the bench's sequence model.
  int cyc = 0, clr_total = 0;
  int re_cnt = 0, ld_cnt = 0, sum_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int stop_e_cnt = 0, stop_a_cnt = 0, we_in_afull = 0;
  int addr_err = 0, ld_err = 0, sel_err = 0, y_err = 0, byp_err = 0;
  int clr_cyc = 0, done_cyc = 0, lastwe_cyc = 0;

  always @(negedge clk) begin
    if (clear) begin
      re_cnt = 0; ld_cnt = 0; sum_cnt = 0; wr_cnt = 0; done_cnt = 0;
      stop_e_cnt = 0; stop_a_cnt = 0; we_in_afull = 0;
      addr_err = 0; ld_err = 0; sel_err = 0; y_err = 0; byp_err = 0;
      clr_total = clr_total + 1;
      clr_cyc = cyc;
    end
    if (Read_Enable) begin
      if (M_addr !== re_cnt[15:0]) addr_err = addr_err + 1;
      re_cnt = re_cnt + 1;
    end
    if (stop_empty) begin
      stop_e_cnt = stop_e_cnt + 1;
      if (Read_Enable || (M_addr !== re_cnt[15:0])) addr_err = addr_err + 1;
    end
    if (Ld_win) begin
      if (ch_sel !== ld_cnt[0]) ld_err = ld_err + 1;
      ld_cnt = ld_cnt + 1;
    end
    if (en_sum) begin
      if (exp_byp) begin
        if ((sel_xi !== 2'd0) || (ch_sel !== sum_cnt[0])) sel_err = sel_err + 1;
      end else begin
        if ((sel_xi !== sum_cnt[1:0]) || (ch_sel !== sum_cnt[2])) sel_err = sel_err + 1;
      end
      sum_cnt = sum_cnt + 1;
    end
    if (stop_Afull) begin
      stop_a_cnt = stop_a_cnt + 1;
      if (Write_Enable) we_in_afull = we_in_afull + 1;
    end
    if (Write_Enable) begin
      if (Y_addr !== wr_cnt[15:0]) y_err = y_err + 1;
      wr_cnt = wr_cnt + 1;
      lastwe_cyc = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (busy && (FIFO_bypass !== exp_byp)) byp_err = byp_err + 1;
    if (!busy && FIFO_bypass) byp_err = byp_err + 1;
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int len, input logic byp, input logic md);
    ilen = len;
    bypass = byp;
    mode = md;
    exp_byp = byp;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && (n < 2000)) begin
      @(negedge clk);
      n = n + 1;
    end
    check({tag, "_timeout"}, 32'(n < 2000), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_re"}, 32'(Read_Enable), 32'd0);
    check({tag, "_maddr"}, 32'(M_addr), 32'd0);
    check({tag, "_yaddr"}, 32'(Y_addr), 32'd0);
    check({tag, "_we"}, 32'(Write_Enable), 32'd0);
    check({tag, "_ensum"}, 32'(en_sum), 32'd0);
    check({tag, "_misc"}, {24'd0, Ld_win, ch_sel, sel_xi, FIFO_bypass, done, clear, stop_empty | stop_Afull}, 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Memory mode, ilen=4; FIFO flags held high must be ignored.
    Empty_i = 1'b1;
    Afull_i = 1'b1;
    run(4, 1'b0, 1'b0);
    wait_done("mem");
    check("mem_reads", re_cnt, 32'd8);
    check("mem_addr_err", addr_err, 32'd0);
    check("mem_ldwin", ld_cnt, 32'd8);
    check("mem_ld_err", ld_err, 32'd0);
    check("mem_ensum", sum_cnt, 32'd16);
    check("mem_sel_err", sel_err, 32'd0);
    check("mem_writes", wr_cnt, 32'd16);
    check("mem_yaddr_err", y_err, 32'd0);
    check("mem_done_cnt", done_cnt, 32'd1);
    check("mem_done_lat", done_cyc - lastwe_cyc, 32'd1);
    check("mem_stops", stop_e_cnt + stop_a_cnt, 32'd0);
    check("mem_yaddr_end", 32'(Y_addr), 32'd16);
    Empty_i = 1'b0;
    Afull_i = 1'b0;

    // Bypass, ilen=3.
    run(3, 1'b1, 1'b0);
    wait_done("byp");
    check("byp_reads", re_cnt, 32'd6);
    check("byp_writes", wr_cnt, 32'd6);
    check("byp_sel_err", sel_err, 32'd0);
    check("byp_yaddr_err", y_err, 32'd0);
    check("byp_fifo_bypass", byp_err, 32'd0);
    check("byp_done_cnt", done_cnt, 32'd1);

    // Stream mode, Empty_i for 5 cycles while stalled on the read of address 4.
    exp_byp = 1'b0;
    run(4, 1'b0, 1'b1);
    n = 0;
    while (!(Read_Enable && (M_addr == 16'd3)) && (n < 200)) begin
      @(negedge clk);
      n = n + 1;
    end
    check("emp_wait", 32'(n < 200), 32'd1);
    @(posedge clk); #1 Empty_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 Empty_i = 1'b0;
    wait_done("emp");
    check("emp_stop_cycles", stop_e_cnt, 32'd5);
    check("emp_addr_err", addr_err, 32'd0);
    check("emp_reads", re_cnt, 32'd8);
    check("emp_writes", wr_cnt, 32'd16);
    check("emp_yaddr_err", y_err, 32'd0);
`ifdef INTPOL_STALL_CNT_EN
    check("emp_stall_cnt", stall_cnt, 32'd5);
`endif

    // Stream mode, Afull_i for 4 cycles inside the first COMP phase.
    run(4, 1'b0, 1'b1);
    n = 0;
    while (!en_sum && (n < 200)) begin
      @(negedge clk);
      n = n + 1;
    end
    check("afull_wait", 32'(n < 200), 32'd1);
    @(posedge clk); #1 Afull_i = 1'b1;
    repeat (4) @(posedge clk);
    #1 Afull_i = 1'b0;
    wait_done("afull");
    check("afull_stop_cycles", stop_a_cnt, 32'd4);
    check("afull_inflight_we", we_in_afull, 32'd2);
    check("afull_ensum", sum_cnt, 32'd16);
    check("afull_sel_err", sel_err, 32'd0);
    check("afull_writes", wr_cnt, 32'd16);
    check("afull_yaddr_err", y_err, 32'd0);

    // ilen=2: no writes, done two cycles after CLEAR; a start while busy is ignored.
    n = clr_total;
    run(2, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("short");
    check("short_writes", wr_cnt, 32'd0);
    check("short_done_cnt", done_cnt, 32'd1);
    check("short_done_lat", done_cyc - clr_cyc, 32'd2);
    check("short_one_clear", clr_total - n, 32'd1);
    check("short_idle", 32'(busy), 32'd0);

    // Reset for one cycle mid-COMP, then rerun.
    run(4, 1'b0, 1'b0);
    n = 0;
    while (!en_sum && (n < 200)) begin
      @(negedge clk);
      n = n + 1;
    end
    check("rst_wait", 32'(n < 200), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt, 32'd0);
    check("midrst_no_we", 32'(Write_Enable), 32'd0);
    run(4, 1'b0, 1'b0);
    wait_done("rerun");
    check("rerun_writes", wr_cnt, 32'd16);
    check("rerun_yaddr_err", y_err, 32'd0);
    check("rerun_done_cnt", done_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
